// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler. Note events are assigned to oscillator voices.
// A held note is retriggered on its own voice. Otherwise the lowest free voice
// is used. If every voice is busy, the oldest voice is stolen. Each voice
// drives an enable and a playback rate. The per-voice samples of the enabled
// voices are also summed, saturated and registered into one output stream.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous reset, active-high
//   valid_in          event strobe, taken when valid_in && ready_out
//   is_note_on_in     1 = note-on, 0 = note-off
//   note_in           MIDI note number
//   rate_in           playback rate for note-on
//   ready_out         allocator idle, can accept an event
//   is_on_out         per-voice enable
//   playback_rate_out packed per-voice rate, voice i at [i*RATE_WIDTH +: RATE_WIDTH]
//   samples_in        packed signed per-voice samples
//   stream_out        signed mixed sample
module voice_allocator #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int RATE_WIDTH      = 24,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int AGE_WIDTH       = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  valid_in,
    input  logic                                  is_note_on_in,
    input  logic [6:0]                            note_in,
    input  logic [RATE_WIDTH-1:0]                 rate_in,
    output logic                                  ready_out,
    output logic [NUM_OSCILLATORS-1:0]            is_on_out,
    output logic [NUM_OSCILLATORS*RATE_WIDTH-1:0] playback_rate_out,
    input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] samples_in,
    output logic [SAMPLE_WIDTH-1:0]               stream_out
);
    localparam int IDX_W = $clog2(NUM_OSCILLATORS);
    localparam int SUM_W = SAMPLE_WIDTH + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OSCILLATORS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;

    state_t state_q, state_d;
    logic   scan_en, commit_en;

    // Latched event and the running results of the voice scan
    logic [6:0]            ev_note_q, ev_note_d;
    logic [RATE_WIDTH-1:0] ev_rate_q, ev_rate_d;
    logic                  ev_on_q, ev_on_d;
    logic [IDX_W-1:0]      k_q, k_d;
    logic                  match_found_q, match_found_d;
    logic [IDX_W-1:0]      match_idx_q, match_idx_d;
    logic                  free_found_q, free_found_d;
    logic [IDX_W-1:0]      free_idx_q, free_idx_d;
    logic                  old_found_q, old_found_d;
    logic [IDX_W-1:0]      old_idx_q, old_idx_d;
    logic [AGE_WIDTH-1:0]  old_age_q, old_age_d;
    logic [IDX_W-1:0]      chosen_idx;

    // Per-voice state gathered from the generate blocks for the scanner
    logic [6:0]           note_arr [NUM_OSCILLATORS];
    logic [AGE_WIDTH-1:0] age_arr  [NUM_OSCILLATORS];

    logic signed [SUM_W-1:0] stream_q, stream_d;

    // FSM: state register
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (valid_in) state_d = ST_SCAN;
            ST_SCAN:   if (k_q == LAST_IDX) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_out = (state_q == ST_IDLE);
        scan_en   = (state_q == ST_SCAN);
        commit_en = (state_q == ST_COMMIT);
    end

    // Event latch and one-voice-per-cycle scan
    always_comb begin
        ev_note_d     = ev_note_q;
        ev_rate_d     = ev_rate_q;
        ev_on_d       = ev_on_q;
        k_d           = k_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        if (ready_out && valid_in) begin
            ev_note_d     = note_in;
            ev_rate_d     = rate_in;
            ev_on_d       = is_note_on_in;
            k_d           = '0;
            match_found_d = 1'b0;
            match_idx_d   = '0;
            free_found_d  = 1'b0;
            free_idx_d    = '0;
            old_found_d   = 1'b0;
            old_idx_d     = '0;
            old_age_d     = '0;
        end else if (scan_en) begin
            k_d = k_q + 1'b1;
            if (is_on_out[k_q]) begin
                if (!match_found_q && note_arr[k_q] == ev_note_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = k_q;
                end
                // Strictly greater keeps the lowest index on equal ages
                if (!old_found_q || age_arr[k_q] > old_age_q) begin
                    old_found_d = 1'b1;
                    old_idx_d   = k_q;
                    old_age_d   = age_arr[k_q];
                end
            end else if (!free_found_q) begin
                free_found_d = 1'b1;
                free_idx_d   = k_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ev_note_q     <= '0;
            ev_rate_q     <= '0;
            ev_on_q       <= 1'b0;
            k_q           <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
        end else begin
            ev_note_q     <= ev_note_d;
            ev_rate_q     <= ev_rate_d;
            ev_on_q       <= ev_on_d;
            k_q           <= k_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
        end
    end

    // Retrigger beats a free voice, and a free voice beats stealing.
    // With no free voice every voice is active, so the oldest one is valid.
    always_comb begin
        if (match_found_q)     chosen_idx = match_idx_q;
        else if (free_found_q) chosen_idx = free_idx_q;
        else                   chosen_idx = old_idx_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OSCILLATORS; gi++) begin : g_voice
            logic                  on_q, on_d;
            logic [6:0]            note_q, note_d;
            logic [RATE_WIDTH-1:0] rate_q, rate_d;
            logic [AGE_WIDTH-1:0]  age_q, age_d;

            always_comb begin
                on_d   = on_q;
                note_d = note_q;
                rate_d = rate_q;
                age_d  = age_q;
                if (commit_en) begin
                    if (ev_on_q) begin
                        if (chosen_idx == IDX_W'(gi)) begin
                            on_d   = 1'b1;
                            note_d = ev_note_q;
                            rate_d = ev_rate_q;
                            age_d  = '0;
                        end else if (on_q && age_q != {AGE_WIDTH{1'b1}}) begin
                            age_d = age_q + 1'b1;
                        end
                    end else if (on_q && note_q == ev_note_q) begin
                        // Rate and age stay as they were
                        on_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    on_q   <= 1'b0;
                    note_q <= '0;
                    rate_q <= '0;
                    age_q  <= '0;
                end else begin
                    on_q   <= on_d;
                    note_q <= note_d;
                    rate_q <= rate_d;
                    age_q  <= age_d;
                end
            end

            assign is_on_out[gi] = on_q;
            assign note_arr[gi]  = note_q;
            assign age_arr[gi]   = age_q;
            assign playback_rate_out[gi*RATE_WIDTH +: RATE_WIDTH] = rate_q;
        end
    endgenerate

    // Mixer: sign-extended sum of enabled voices, saturated to the sample range
    always_comb begin
        logic signed [SUM_W-1:0] mix_sum;
        logic [SAMPLE_WIDTH-1:0] smp;
        mix_sum = '0;
        smp     = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            smp = samples_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            if (is_on_out[i]) begin
                mix_sum = mix_sum + {{IDX_W{smp[SAMPLE_WIDTH-1]}}, smp};
            end
        end
        if (mix_sum > SAT_MAX)      stream_d = SAT_MAX;
        else if (mix_sum < SAT_MIN) stream_d = SAT_MIN;
        else                        stream_d = mix_sum;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) stream_q <= '0;
        else        stream_q <= stream_d;
    end

    assign stream_out = stream_q[SAMPLE_WIDTH-1:0];

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed note events and sample patterns.
// A behavioural model of the allocation rules and the mixer is checked
// against the DUT on every cycle. Hand-computed literal checks pin the
// scenarios.
module tb_voice_allocator;
    localparam int N  = 4;
    localparam int RW = 24;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic            on_in = 1'b0;
    logic [6:0]      note = '0;
    logic [RW-1:0]   rate = '0;
    logic [N*SW-1:0] samples = '0;
    logic            ready;
    logic [N-1:0]    is_on;
    logic [N*RW-1:0] rates;
    logic [SW-1:0]   stream;

    int total = 0;
    int bad = 0;
    logic check_en = 1'b0;

    voice_allocator #(
        .NUM_OSCILLATORS(N), .RATE_WIDTH(RW), .SAMPLE_WIDTH(SW), .AGE_WIDTH(8)
    ) dut (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .is_note_on_in(on_in),
        .note_in(note), .rate_in(rate), .ready_out(ready), .is_on_out(is_on),
        .playback_rate_out(rates), .samples_in(samples), .stream_out(stream)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic          m_on   [N];
    int            m_note [N];
    int            m_rate [N];
    int            m_age  [N];
    int            m_busy;
    logic          m_ev_on;
    int            m_ev_note;
    int            m_ev_rate;
    logic [SW-1:0] m_stream;

    task automatic model_commit();
        int ch;
        ch = -1;
        if (m_ev_on) begin
            for (int i = 0; i < N; i++)
                if (ch < 0 && m_on[i] && m_note[i] == m_ev_note) ch = i;
            for (int i = 0; i < N; i++)
                if (ch < 0 && !m_on[i]) ch = i;
            if (ch < 0) begin
                ch = 0;
                for (int i = 1; i < N; i++)
                    if (m_age[i] > m_age[ch]) ch = i;
            end
            for (int i = 0; i < N; i++) begin
                if (i == ch) begin
                    m_on[i] = 1'b1; m_note[i] = m_ev_note;
                    m_rate[i] = m_ev_rate; m_age[i] = 0;
                end else if (m_on[i] && m_age[i] < 255) begin
                    m_age[i]++;
                end
            end
        end else begin
            for (int i = 0; i < N; i++)
                if (m_on[i] && m_note[i] == m_ev_note) m_on[i] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_on[i] = 1'b0; m_note[i] = 0; m_rate[i] = 0; m_age[i] = 0;
            end
            m_busy = 0;
            m_stream = '0;
        end else begin
            int sum;
            sum = 0;
            for (int i = 0; i < N; i++) begin
                int s;
                s = $signed(samples[i*SW +: SW]);
                if (m_on[i]) sum += s;
            end
            if (sum > 32767) sum = 32767;
            if (sum < -32768) sum = -32768;
            m_stream = sum[SW-1:0];
            if (m_busy == 0) begin
                if (valid) begin
                    m_ev_on = on_in; m_ev_note = note; m_ev_rate = rate;
                    m_busy = N + 1;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) model_commit();
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            logic [N-1:0] exp_on;
            for (int i = 0; i < N; i++) exp_on[i] = m_on[i];
            chk("model_ready", {63'b0, ready}, {63'b0, (m_busy == 0)});
            chk("model_is_on", 64'(is_on), 64'(exp_on));
            for (int i = 0; i < N; i++)
                chk($sformatf("model_rate%0d", i), 64'(rates[i*RW +: RW]), 64'(m_rate[i]));
            chk("model_stream", 64'(stream), 64'(m_stream));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [RW-1:0] vrate(input int v);
        return rates[v*RW +: RW];
    endfunction

    task automatic issue(input logic on, input logic [6:0] n, input logic [RW-1:0] r);
        int w;
        w = 0;
        while (!ready && w < 50) begin
            @(posedge clk); #2;
            w++;
        end
        if (!ready) chk("ready_wait", {63'b0, ready}, 64'd1);
        valid = 1'b1; on_in = on; note = n; rate = r;
        @(posedge clk); #2;
        valid = 1'b0;
    endtask

    task automatic settle();
        repeat (N + 1) @(posedge clk);
        #2;
    endtask

    task automatic set_all(input logic [SW-1:0] v);
        for (int i = 0; i < N; i++) samples[i*SW +: SW] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        check_en = 1'b1;
        #2;
        rst = 1'b0;
        chk("reset_is_on", 64'(is_on), 64'h0);
        chk("reset_ready", {63'b0, ready}, 64'd1);
        chk("reset_stream", 64'(stream), 64'h0);
        chk("reset_rates", 64'(rates), 64'h0);

        // First note-on: commit exactly at the edge ending cycle t+N+1
        issue(1'b1, 7'd60, 24'h000800);
        repeat (N) @(posedge clk);
        #2;
        chk("t1_before_is_on", 64'(is_on), 64'h0);
        chk("t1_before_ready", {63'b0, ready}, 64'd0);
        @(posedge clk); #2;
        chk("t1_is_on", 64'(is_on), 64'h1);
        chk("t1_rate0", 64'(vrate(0)), 64'h000800);
        chk("t1_ready", {63'b0, ready}, 64'd1);

        // Fill the remaining voices, then steal the oldest (voice 0)
        issue(1'b1, 7'd62, 24'h000900); settle();
        issue(1'b1, 7'd64, 24'h000A00); settle();
        issue(1'b1, 7'd67, 24'h000B00); settle();
        issue(1'b1, 7'd72, 24'h000400); settle();
        chk("steal_is_on", 64'(is_on), 64'hF);
        chk("steal_rate0", 64'(vrate(0)), 64'h000400);
        chk("steal_rate1", 64'(vrate(1)), 64'h000900);

        // Retrigger of a held note updates only its voice
        issue(1'b1, 7'd62, 24'h000500); settle();
        chk("retrig_rate1", 64'(vrate(1)), 64'h000500);
        chk("retrig_rate0", 64'(vrate(0)), 64'h000400);
        chk("retrig_rate2", 64'(vrate(2)), 64'h000A00);
        chk("retrig_rate3", 64'(vrate(3)), 64'h000B00);
        chk("retrig_is_on", 64'(is_on), 64'hF);

        // Note-offs: held note clears its voice, unheld note changes nothing
        issue(1'b0, 7'd64, 24'h0); settle();
        chk("off64_is_on", 64'(is_on), 64'hB);
        chk("off64_rate2", 64'(vrate(2)), 64'h000A00);
        issue(1'b0, 7'd50, 24'h0); settle();
        chk("off50_is_on", 64'(is_on), 64'hB);

        // Free voice reused, then a steal that must skip the retriggered voice 1
        issue(1'b1, 7'd76, 24'h000700); settle();
        chk("free_rate2", 64'(vrate(2)), 64'h000700);
        chk("free_is_on", 64'(is_on), 64'hF);
        issue(1'b1, 7'd79, 24'h000300); settle();
        chk("steal2_rate3", 64'(vrate(3)), 64'h000300);
        chk("steal2_rate1", 64'(vrate(1)), 64'h000500);

        // Mixer saturation and voice removal
        set_all(16'h7000);
        repeat (2) @(posedge clk); #2;
        chk("mix_pos_sat", 64'(stream), 64'h7FFF);
        set_all(16'h9000);
        repeat (2) @(posedge clk); #2;
        chk("mix_neg_sat", 64'(stream), 64'h8000);
        samples = {16'hFFFF, 16'h0005, 16'h9000, 16'h7000};
        repeat (2) @(posedge clk); #2;
        chk("mix_signed", 64'(stream), 64'h0004);
        samples = {16'h0001, 16'h0010, 16'h0100, 16'h1000};
        repeat (2) @(posedge clk); #2;
        chk("mix_all", 64'(stream), 64'h1111);
        issue(1'b0, 7'd62, 24'h0);
        repeat (N + 1) @(posedge clk); #2;
        chk("mix_off_is_on", 64'(is_on), 64'hD);
        chk("mix_off_same_cycle", 64'(stream), 64'h1111);
        @(posedge clk); #2;
        chk("mix_off_next_cycle", 64'(stream), 64'h1011);

        // Reset mid-scan aborts the event
        rst = 1'b1; @(posedge clk); #2; rst = 1'b0;
        issue(1'b1, 7'd60, 24'h000800);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("abort_is_on", 64'(is_on), 64'h0);
        chk("abort_ready", {63'b0, ready}, 64'd1);
        repeat (N + 3) @(posedge clk); #2;
        chk("abort_later_is_on", 64'(is_on), 64'h0);
        chk("abort_stream", 64'(stream), 64'h0);

        // Event offered while busy is dropped
        issue(1'b1, 7'd60, 24'h000800);
        valid = 1'b1; on_in = 1'b1; note = 7'd62; rate = 24'h000900;
        @(posedge clk); #2;
        valid = 1'b0;
        repeat (N + 4) @(posedge clk); #2;
        chk("drop_is_on", 64'(is_on), 64'h1);
        chk("drop_rate1", 64'(vrate(1)), 64'h0);
        chk("drop_rate0", 64'(vrate(0)), 64'h000800);

        repeat (2) @(posedge clk); #2;
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
